// File: rtl/gh_uart_pkg.sv
// -----------------------------------------------------------------------------
// gh_uart_pkg
//
// Shared definitions for the UART transmit/receive arbitration blocks.
//
// Contents:
//   ARB_MAX_REQ    - largest number of requesters any arbiter may be built for
//   ARB_IDX_W      - width of a requester index / round-robin pointer
//   t_arb_state_e  - states of the packet-level TX arbiter
//   onehot_to_idx  - converts a one-hot requester vector into its index
// -----------------------------------------------------------------------------
package gh_uart_pkg;

    localparam int ARB_MAX_REQ = 8;
    localparam int ARB_IDX_W   = 3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        DRAIN   = 3'd2,
        GAP     = 3'd3,
        RELEASE = 3'd4
    } t_arb_state_e;

    // OR-reduction encoder: exact for one-hot inputs, returns 0 for all-zero.
    function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(
        input logic [ARB_MAX_REQ-1:0] oh
    );
        logic [ARB_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | ARB_IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/gh_rr_arbiter.sv
// -----------------------------------------------------------------------------
// gh_rr_arbiter
//
// Combinational round-robin pick: finds the first asserted request at or after
// the pointer position, wrapping modulo NUM_REQ.
//
// Parameters:
//   NUM_REQ - number of request lines (2..ARB_MAX_REQ)
//
// Ports:
//   req  in  NUM_REQ    request vector
//   ptr  in  ARB_IDX_W  index that has highest priority; must be < NUM_REQ
//   win  out NUM_REQ    one-hot winner, all-zero when no request
//   any  out 1          at least one request is asserted
// -----------------------------------------------------------------------------
module gh_rr_arbiter
    import gh_uart_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [ARB_IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0]   win,
    output logic                 any
);

    always_comb begin
        int idx;
        win = '0;
        any = 1'b0;
        idx = 0;
        // Walk the requesters in priority order starting at ptr; the first
        // hit wins and masks every later candidate.
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(ptr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!any && req[idx]) begin
                win[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gh_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// gh_uart_tx_arbiter
//
// Shares one gh_uart_tx_8bit transmitter between NUM_REQ byte-stream
// requesters. Ownership is granted per packet (round robin) and held until the
// packet's last byte has left the transmitter, so packets never interleave on
// the serial line. After the last byte is read, the grant is released once the
// transmitter reports idle, optionally followed by GAP_CYCLES quiet cycles.
//
// Requester handshake: a byte transfers on a rising clk edge where
// req_valid[i] and req_ready[i] are both high. req_ready is combinational and
// only ever asserted for the current owner. Transmitter handshake: tx_d is
// offered while tx_d_ryn is low; a one-cycle tx_read pulse consumes it.
//
// Parameters:
//   NUM_REQ    - number of requesters (2..8)
//   GAP_CYCLES - extra idle cycles between packets (0 = none)
//
// Ports:
//   clk         in  1          clock
//   rst         in  1          synchronous active-high reset
//   req_valid   in  NUM_REQ    requester i presents a byte
//   req_data    in  8*NUM_REQ  byte of requester i at [8i+7:8i]
//   req_last    in  NUM_REQ    byte ends requester i's packet
//   req_ready   out NUM_REQ    byte accepted this cycle (one-hot or zero)
//   grant       out NUM_REQ    registered one-hot packet owner
//   tx_d        out 8          byte to the transmitter
//   tx_d_ryn    out 1          active-low data ready to the transmitter
//   tx_read     in  1          transmitter consumed tx_d (pulse)
//   tx_busyn    in  1          transmitter idle (active high)
//   dbg_state   out 3          current arbiter state (t_arb_state_e)
//   dbg_rr_ptr  out ARB_IDX_W  current round-robin pointer
// -----------------------------------------------------------------------------
module gh_uart_tx_arbiter
    import gh_uart_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic [7:0]             tx_d,
    output logic                   tx_d_ryn,
    input  logic                   tx_read,
    input  logic                   tx_busyn,
    output logic [2:0]             dbg_state,
    output logic [ARB_IDX_W-1:0]   dbg_rr_ptr
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0]     GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [ARB_IDX_W-1:0] LAST_IDX = ARB_IDX_W'(NUM_REQ - 1);

    t_arb_state_e         state;
    logic [ARB_IDX_W-1:0] owner_idx;
    logic [ARB_IDX_W-1:0] rr_ptr;
    logic [7:0]           hold_data;
    logic                 hold_full;
    logic                 hold_last;
    logic                 drain_first;
    logic [GAP_W-1:0]     gap_cnt;

    logic [NUM_REQ-1:0]   arb_win;
    logic                 arb_any;
    logic [7:0]           own_data;
    logic                 own_last;
    logic                 hold_room;
    logic                 accept;

    gh_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req (req_valid),
        .ptr (rr_ptr),
        .win (arb_win),
        .any (arb_any)
    );

    // Owner's byte and last flag, selected by the one-hot grant.
    always_comb begin
        own_data = '0;
        own_last = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                own_data = req_data[i*8 +: 8];
                own_last = req_last[i];
            end
        end
    end

    // The hold register can take a byte when it is empty or is being read
    // this very cycle (back-to-back refill). Once the last byte of a packet is
    // held, nothing more is taken until the packet is finished. The state
    // qualifier keeps the owner from being accepted while draining.
    assign hold_room = (~hold_full | tx_read) & ~hold_last;
    assign req_ready = (state == SEND && hold_room) ? (grant & req_valid) : '0;
    assign accept    = |req_ready;

    assign tx_d       = hold_data;
    assign tx_d_ryn   = ~hold_full;
    assign dbg_state  = state;
    assign dbg_rr_ptr = rr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= '0;
            owner_idx   <= '0;
            rr_ptr      <= '0;
            hold_data   <= 8'h00;
            hold_full   <= 1'b0;
            hold_last   <= 1'b0;
            drain_first <= 1'b0;
            gap_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_any) begin
                        grant     <= arb_win;
                        owner_idx <= onehot_to_idx(ARB_MAX_REQ'(arb_win));
                        state     <= SEND;
                    end
                end

                SEND: begin
                    if (accept) begin
                        hold_data <= own_data;
                        hold_full <= 1'b1;
                        hold_last <= own_last;
                    end else if (tx_read && hold_full) begin
                        // A read with nothing to refill empties the register;
                        // a read of an empty register is a no-op.
                        hold_full <= 1'b0;
                        if (hold_last) begin
                            hold_last   <= 1'b0;
                            drain_first <= 1'b1;
                            state       <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    // The transmitter may still report idle in the cycle right
                    // after its read, before it has started shifting the last
                    // byte, so busyn is not trusted in the first DRAIN cycle.
                    if (drain_first) begin
                        drain_first <= 1'b0;
                    end else if (tx_busyn) begin
                        if (GAP_CYCLES == 0) begin
                            state <= RELEASE;
                        end else begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end
                    end
                end

                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= RELEASE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    grant  <= '0;
                    rr_ptr <= (owner_idx == LAST_IDX) ? '0 : (owner_idx + 1'b1);
                    state  <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gh_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gh_uart_tx_arbiter
//
// Bench for gh_uart_tx_arbiter (NUM_REQ = 4). Two instances share the input
// stimulus: dut (GAP_CYCLES = 0) and dut_g (GAP_CYCLES = 5); dut_g is only
// inspected in the gap-timing sequence.
// -----------------------------------------------------------------------------
module tb_gh_uart_tx_arbiter;
    import gh_uart_pkg::*;

    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic           tx_read;
    logic           tx_busyn;

    logic [N-1:0]   req_ready,   g_req_ready;
    logic [N-1:0]   grant,       g_grant;
    logic [7:0]     tx_d,        g_tx_d;
    logic           tx_d_ryn,    g_tx_d_ryn;
    logic [2:0]     dbg_state,   g_dbg_state;
    logic [ARB_IDX_W-1:0] dbg_rr_ptr, g_dbg_rr_ptr;

    gh_uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .grant(grant),
        .tx_d(tx_d), .tx_d_ryn(tx_d_ryn), .tx_read(tx_read), .tx_busyn(tx_busyn),
        .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr)
    );

    gh_uart_tx_arbiter #(.NUM_REQ(N), .GAP_CYCLES(5)) dut_g (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(g_req_ready), .grant(g_grant),
        .tx_d(g_tx_d), .tx_d_ryn(g_tx_d_ryn), .tx_read(tx_read), .tx_busyn(tx_busyn),
        .dbg_state(g_dbg_state), .dbg_rr_ptr(g_dbg_rr_ptr)
    );

    // ---------------- scoreboard bookkeeping ----------------
    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_read   = 1'b0;
        tx_busyn  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Transmitter model: after each read it is busy for a while, then idle.
    int busy_cnt = 0;
    task automatic tx_drive(input bit rand_en);
        tx_busyn = (busy_cnt == 0);
        tx_read  = (busy_cnt == 0) && (tx_d_ryn == 1'b0) &&
                   (!rand_en || ($urandom_range(0, 3) != 0));
        if (tx_read) begin
            busy_cnt = rand_en ? int'($urandom_range(1, 6)) : 3;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic [3:0] last;
        logic [31:0] data;
        logic       rd;
        logic       busyn;
        logic [3:0] exp_ready;   // combinational, before the edge
        logic [3:0] exp_grant;   // after the edge
        logic       exp_ryn;
        logic [7:0] exp_txd;
        logic [2:0] exp_ptr;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs[NV];

    function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                                logic rd, logic bn, logic [3:0] er, logic [3:0] eg,
                                logic eryn, logic [7:0] etxd, logic [2:0] ep);
        vec_t t;
        t.rst = r; t.valid = v; t.last = l; t.data = d; t.rd = rd; t.busyn = bn;
        t.exp_ready = er; t.exp_grant = eg; t.exp_ryn = eryn; t.exp_txd = etxd;
        t.exp_ptr = ep;
        return t;
    endfunction

    task automatic fill_vectors();
        //            rst valid    last     data          rd  bn   ready    grant   ryn  txd    ptr
        vecs[0]  = mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 1, 4'b0000, 4'b0000, 1, 8'h00, 3'd0);
        vecs[1]  = mk(0, 4'b0001, 4'b0000, 32'h00000011, 0, 1, 4'b0000, 4'b0001, 1, 8'h00, 3'd0);
        vecs[2]  = mk(0, 4'b0001, 4'b0000, 32'h00000011, 0, 1, 4'b0001, 4'b0001, 0, 8'h11, 3'd0);
        vecs[3]  = mk(0, 4'b0001, 4'b0000, 32'h00000022, 0, 1, 4'b0000, 4'b0001, 0, 8'h11, 3'd0);
        vecs[4]  = mk(0, 4'b0001, 4'b0000, 32'h00000022, 1, 1, 4'b0001, 4'b0001, 0, 8'h22, 3'd0);
        vecs[5]  = mk(0, 4'b0000, 4'b0000, 32'h00000022, 0, 0, 4'b0000, 4'b0001, 0, 8'h22, 3'd0);
        vecs[6]  = mk(0, 4'b0001, 4'b0001, 32'h00000033, 0, 0, 4'b0000, 4'b0001, 0, 8'h22, 3'd0);
        vecs[7]  = mk(0, 4'b0001, 4'b0001, 32'h00000033, 1, 0, 4'b0001, 4'b0001, 0, 8'h33, 3'd0);
        vecs[8]  = mk(0, 4'b0100, 4'b0100, 32'h00440000, 0, 0, 4'b0000, 4'b0001, 0, 8'h33, 3'd0);
        vecs[9]  = mk(0, 4'b0100, 4'b0100, 32'h00440000, 1, 0, 4'b0000, 4'b0001, 1, 8'h33, 3'd0);
        vecs[10] = mk(0, 4'b0100, 4'b0100, 32'h00440000, 0, 1, 4'b0000, 4'b0001, 1, 8'h33, 3'd0);
        vecs[11] = mk(0, 4'b0100, 4'b0100, 32'h00440000, 0, 0, 4'b0000, 4'b0001, 1, 8'h33, 3'd0);
        vecs[12] = mk(0, 4'b0100, 4'b0100, 32'h00440000, 0, 1, 4'b0000, 4'b0001, 1, 8'h33, 3'd0);
        vecs[13] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0000, 4'b0000, 1, 8'h33, 3'd1);
        vecs[14] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0000, 4'b0100, 1, 8'h33, 3'd1);
        vecs[15] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0100, 4'b0100, 0, 8'h44, 3'd1);
        vecs[16] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0000, 4'b0100, 0, 8'h44, 3'd1);
        vecs[17] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 1, 1, 4'b0000, 4'b0100, 1, 8'h44, 3'd1);
        vecs[18] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0000, 4'b0100, 1, 8'h44, 3'd1);
        vecs[19] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0000, 4'b0100, 1, 8'h44, 3'd1);
        vecs[20] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0000, 4'b0000, 1, 8'h44, 3'd3);
        vecs[21] = mk(0, 4'b0101, 4'b0101, 32'h00440066, 0, 1, 4'b0000, 4'b0001, 1, 8'h44, 3'd3);
        vecs[22] = mk(0, 4'b0000, 4'b0000, 32'h00000000, 1, 1, 4'b0000, 4'b0001, 1, 8'h44, 3'd3);
        vecs[23] = mk(0, 4'b0001, 4'b0000, 32'h00000055, 0, 1, 4'b0001, 4'b0001, 0, 8'h55, 3'd3);
        vecs[24] = mk(1, 4'b1001, 4'b0000, 32'h77000055, 0, 1, 4'b0000, 4'b0000, 1, 8'h00, 3'd0);
        vecs[25] = mk(0, 4'b1001, 4'b0000, 32'h77000055, 0, 1, 4'b0000, 4'b0001, 1, 8'h00, 3'd0);
    endtask

    task automatic run_table();
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            req_valid = vecs[i].valid;
            req_last  = vecs[i].last;
            req_data  = vecs[i].data;
            tx_read   = vecs[i].rd;
            tx_busyn  = vecs[i].busyn;
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
            check($sformatf("v%0d_ryn", i), 32'(tx_d_ryn), 32'(vecs[i].exp_ryn));
            check($sformatf("v%0d_txd", i), 32'(tx_d), 32'(vecs[i].exp_txd));
            check($sformatf("v%0d_ptr", i), 32'(dbg_rr_ptr), 32'(vecs[i].exp_ptr));
        end
    endtask

    // ---------------- gap timing: GAP_CYCLES=0 vs 5 ----------------
    task automatic run_gap();
        int rel0;
        int relg;
        rel0 = -1;
        relg = -1;
        do_reset();
        req_valid = 4'b0001;
        req_last  = 4'b0001;
        req_data  = 32'h0000005A;
        tx_busyn  = 1'b1;
        @(posedge clk);               // grant
        @(negedge clk);
        check("gap_first_ready", 32'(req_ready & g_req_ready), 32'h1);
        @(posedge clk);               // accept
        @(negedge clk);
        req_valid = '0;
        tx_read   = 1'b1;
        @(posedge clk);               // last byte read
        @(negedge clk);
        tx_read = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (rel0 < 0 && grant == '0) rel0 = c;
            if (relg < 0 && g_grant == '0) relg = c;
        end
        check("gap0_release", 32'(rel0), 32'd3);
        check("gap5_release", 32'(relg), 32'd8);
        check("gap_delta", 32'(relg - rel0), 32'd5);
    endtask

    // ---------------- fairness: all valid, single-byte packets ----------------
    task automatic run_fair();
        logic [N-1:0] order[5];
        logic [N-1:0] exp_order[5];
        logic [N-1:0] prev;
        int n;
        exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
        for (int k = 0; k < 5; k++) order[k] = '0;
        do_reset();
        busy_cnt  = 0;
        prev      = '0;
        n         = 0;
        req_valid = 4'b1111;
        req_last  = 4'b1111;
        req_data  = 32'hD4C3B2A1;
        for (int c = 0; c < 400 && n < 5; c++) begin
            @(negedge clk);
            if (prev == '0 && grant != '0) begin
                order[n] = grant;
                n++;
            end
            prev = grant;
            tx_drive(1'b0);
        end
        check("fair_count", 32'(n), 32'd5);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("fair_grant%0d", k), 32'(order[k]), 32'(exp_order[k]));
        end
        @(negedge clk);
        tx_read   = 1'b0;
        req_valid = '0;
    endtask

    // ---------------- randomized packets vs reference model ----------------
    task automatic run_random();
        logic [8:0] src_q[N][$];
        int rem[N];
        int cur[N];
        int p;
        int win;
        int idle_ct;
        bit done;
        logic [8:0] b;

        // Packets per requester; bit 8 marks the last byte.
        for (int i = 0; i < N; i++) begin
            rem[i] = int'($urandom_range(1, 5));
            cur[i] = 0;
            for (int k = 0; k < rem[i]; k++) begin
                int len;
                len = int'($urandom_range(1, 4));
                for (int j = 0; j < len; j++) begin
                    src_q[i].push_back({(j == len - 1), 8'($urandom)});
                end
            end
        end

        // Reference: whole packets, winner = first requester with packets left
        // at or after the pointer, pointer moves past the winner.
        p = 0;
        forever begin
            win = -1;
            for (int off = 0; off < N; off++) begin
                if (win < 0 && rem[(p + off) % N] > 0) win = (p + off) % N;
            end
            if (win < 0) break;
            forever begin
                b = src_q[win][cur[win]];
                cur[win]++;
                exp_q.push_back(b[7:0]);
                if (b[8]) break;
            end
            rem[win]--;
            p = (win + 1) % N;
        end

        do_reset();
        busy_cnt = 0;
        idle_ct  = 0;
        done     = 1'b0;
        for (int cyc = 0; cyc < 20000 && !done; cyc++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && grant == '0 && tx_d_ryn) idle_ct++;
            else idle_ct = 0;
            if (idle_ct > 5) done = 1'b1;

            tx_drive(1'b1);
            if (tx_read) begin
                if (exp_q.size() == 0) check("stream_extra_byte", 32'(tx_d), 32'h100);
                else check("stream_byte", 32'(tx_d), 32'(exp_q.pop_front()));
            end

            for (int i = 0; i < N; i++) begin
                if (src_q[i].size() > 0) begin
                    // Only the current owner may pause mid-packet.
                    req_valid[i]      = !(grant[i] && ($urandom_range(0, 4) == 0));
                    req_data[i*8 +: 8] = src_q[i][0][7:0];
                    req_last[i]       = src_q[i][0][8];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[i*8 +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
            #1;
            check("ready_owner_only",
                  32'(((req_ready & ~grant) == '0) && $onehot0(req_ready)), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (req_ready[i]) begin
                    if (src_q[i].size() > 0) void'(src_q[i].pop_front());
                    else check("ready_without_data", 32'(i), 32'hFF);
                end
            end
        end
        check("random_done", 32'(done), 32'd1);
        check("random_leftover", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        tx_read   = 1'b0;
        req_valid = '0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_read   = 1'b0;
        tx_busyn  = 1'b1;
        repeat (2) @(posedge clk);

        fill_vectors();
        run_table();
        run_gap();
        run_fair();
        run_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
